jtkiwi_gfx_arb: RTL and testbench
=================================

Name: jtkiwi_gfx_arb

Overview:
- Time-slot arbiter for the two GFX-side read ports of the video chip: the 16-bit tilemap/object VRAM port and the 8-bit column/Y LUT port.
- Shares them between the tilemap fetcher and the object fetcher on a 4-cycle rotation.
- Returns read data with a fixed latency and issues a slot strobe that tilemap logic uses as its lookup enable.
- Sits between jtkiwi_tilemap / object engine and the dual-port RAMs inside jtkiwi_gfx.

Parameters:
MEM_LAT, 1, RAM read latency in clk cycles (legal 1..3)
SHARE, 1, 1 = an idle owner's slot may be granted to the other requester; 0 = strict slots
VAW, 12, VRAM address width
LAW, 10, LUT address width

Ports:
clk  in  1  system clock; only clock
rst_n  in  1  asynchronous active-low reset
sync  in  1  realign rotation; level-sampled
tm_req  in  1  tilemap read request, held until ack
tm_vaddr  in  VAW  tilemap VRAM address
tm_laddr  in  LAW  tilemap LUT address
tm_ack  out  1  grant pulse, combinational
tm_dvalid  out  1  tilemap read data valid pulse
tm_vdata  out  16  tilemap VRAM data, held
tm_ldata  out  8  tilemap LUT data, held
obj_req  in  1  object read request
obj_vaddr  in  VAW  object VRAM address
obj_laddr  in  LAW  object LUT address
obj_ack  out  1  grant pulse
obj_dvalid  out  1  object data valid pulse
obj_vdata  out  16  object VRAM data
obj_ldata  out  8  object LUT data
vram_addr  out  VAW  VRAM GFX-port address
vram_q  in  16  VRAM GFX-port data
lut_addr  out  LAW  LUT GFX-port address
lut_q  in  8  LUT GFX-port data
slot_cen  out  1  high for one cycle when slot==0
slot  out  2  current slot number

Behaviour:
- Reset values (rst_n low, async):
  - slot=0, slot_cen=0.
  - Both dvalid=0; all data outputs 0.
  - Pipeline tags cleared.
  - vram_addr/lut_addr=0.
- Rotation:
  - 2-bit slot counter increments every clk, wraps 3->0.
  - slot_cen registered: high in the cycle where slot==0.
  - Slots 0,1 are owned by the tilemap; slots 2,3 by the object fetcher.
- sync:
  - If sync is high at a clock edge, slot becomes 0 on that edge. Held high, slot stays 0, i.e. tilemap-owned.
  - In-flight reads are not cancelled.
- Grant, combinational within cycle t:
  - The owner is granted if its req=1.
  - Otherwise, if SHARE=1 and the other requester has req=1, the other requester is granted.
  - Otherwise no grant.
  - At most one ack per cycle; both requesting means the owner wins.
  - Granted requester's ack=1.
  - vram_addr/lut_addr = granted requester's addresses. With no grant they are 0.
  - Requester may change address or drop req the cycle after ack. Holding req gets another grant at the next eligible slot; back-to-back acks are legal.
- Return path:
  - A grant at cycle t pushes a 1-bit valid plus a 1-bit owner tag into a MEM_LAT-deep shift pipeline.
  - At the end of cycle t+MEM_LAT, vram_q/lut_q are captured into the tagged requester's data registers.
  - That requester's dvalid is high in cycle t+MEM_LAT+1 for exactly one cycle.
  - Total latency is MEM_LAT+1.
  - Data registers hold their value until the next capture for that requester.
- Boundary cases:
  - Both requesters idle: pipeline advances with valid=0; no dvalid.
  - One grant per cycle: at most one dvalid per cycle.
  - SHARE=0: the non-owner waits, possibly up to 3 cycles, even if the owner is idle.
  - rst_n asserted mid-operation: all pending returns are dropped, no dvalid after release, data registers cleared, rotation restarts at slot 0.
  - sync coincident with a grant: the grant completes normally; the new slot numbering applies from the next cycle.
- Widths: addresses pass through unmodified; no arithmetic except the slot counter.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, release -> slot counts 0,1,2,3,0; slot_cen high every 4th cycle, starting at the first slot==0 after release; all dvalid=0.
- Tilemap-only, SHARE=1, MEM_LAT=1: tm_req held, tm_vaddr=12'h123, RAM model returns 16'hA55A -> tm_ack every cycle; vram_addr=12'h123; tm_vdata=16'hA55A with tm_dvalid 2 cycles after each ack.
- Contention: both req held, SHARE=1 -> tm_ack in slots 0,1; obj_ack in slots 2,3; never both in one cycle.
- Strict slots: SHARE=0, only obj_req held -> obj_ack only in slots 2,3; vram_addr=0 in slots 0,1.
- Latency: MEM_LAT=3, single obj grant at slot 2 with obj_laddr=10'h2F0, lut_q=8'h7E -> obj_dvalid exactly 4 cycles later with obj_ldata=8'h7E; obj_ldata holds afterwards.
- Reset and sync mid-flight: grant at slot 1, drop rst_n the next cycle -> no tm_dvalid after release. Separately, pulse sync at slot 2 -> slot=0 next cycle and the earlier grant's dvalid still arrives on time.

Source files
------------

// File: rtl/jtkiwi_gfx_arb_if.sv
// GFX read-port bundle between the tile/object fetchers, the arbiter and the VRAM/LUT RAMs.
// Latency: none, this file only declares wires.
// Backpressure: requesters hold req until ack; there is no stall on the return path.
// slave  : arbiter view (requests and RAM data in; acks, return data and RAM addresses out).
// master : requester/RAM view, the mirror of slave.
interface jtkiwi_gfx_arb_if #(
  parameter int VAW = 12,
  parameter int LAW = 10
);
  logic           tm_req;
  logic [VAW-1:0] tm_vaddr;
  logic [LAW-1:0] tm_laddr;
  logic           tm_ack;
  logic           tm_dvalid;
  logic [15:0]    tm_vdata;
  logic [7:0]     tm_ldata;
  logic           obj_req;
  logic [VAW-1:0] obj_vaddr;
  logic [LAW-1:0] obj_laddr;
  logic           obj_ack;
  logic           obj_dvalid;
  logic [15:0]    obj_vdata;
  logic [7:0]     obj_ldata;
  logic [VAW-1:0] vram_addr;
  logic [15:0]    vram_q;
  logic [LAW-1:0] lut_addr;
  logic [7:0]     lut_q;
  logic           slot_cen;
  logic [1:0]     slot;

  modport slave (
    input  tm_req, tm_vaddr, tm_laddr, obj_req, obj_vaddr, obj_laddr, vram_q, lut_q,
    output tm_ack, tm_dvalid, tm_vdata, tm_ldata,
    output obj_ack, obj_dvalid, obj_vdata, obj_ldata,
    output vram_addr, lut_addr, slot_cen, slot
  );

  modport master (
    output tm_req, tm_vaddr, tm_laddr, obj_req, obj_vaddr, obj_laddr, vram_q, lut_q,
    input  tm_ack, tm_dvalid, tm_vdata, tm_ldata,
    input  obj_ack, obj_dvalid, obj_vdata, obj_ldata,
    input  vram_addr, lut_addr, slot_cen, slot
  );
endinterface

// File: rtl/jtkiwi_gfx_arb.sv
// Time-slot arbiter sharing the GFX VRAM (16b) and LUT (8b) read ports between tilemap and object fetchers.
// Latency: grant is combinational; read data and its dvalid pulse appear MEM_LAT+1 cycles after ack.
// Backpressure: req is held until ack; the return path never stalls.
// Ports: clk / rst_n (async, active low) / sync (forces slot 0 at the next edge);
//        bus (slave modport): per-requester req/addr/ack/dvalid/data, RAM addresses and data, slot and slot_cen.
module jtkiwi_gfx_arb #(
  parameter int MEM_LAT = 1,
  parameter int SHARE   = 1,
  parameter int VAW     = 12,
  parameter int LAW     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync,
  jtkiwi_gfx_arb_if.slave   bus
);

  localparam bit SHARE_EN = (SHARE != 0);

  typedef logic [MEM_LAT-1:0] pipe_t;

  logic [1:0]  slot_q, slot_d;
  logic        slot_cen_q, slot_cen_d;
  pipe_t       pv_q, pv_d;   // return-pipe valid bits, stage 0 = newest grant
  pipe_t       pt_q, pt_d;   // return-pipe owner tags, 1 = object fetcher
  logic        tm_dvalid_q, tm_dvalid_d;
  logic        obj_dvalid_q, obj_dvalid_d;
  logic [15:0] tm_vdata_q, tm_vdata_d;
  logic [7:0]  tm_ldata_q, tm_ldata_d;
  logic [15:0] obj_vdata_q, obj_vdata_d;
  logic [7:0]  obj_ldata_q, obj_ldata_d;

  logic           tm_own;
  logic           tm_gnt;
  logic           obj_gnt;
  logic           ret_vld;
  logic           ret_obj;
  logic [VAW-1:0] vaddr_sel;
  logic [LAW-1:0] laddr_sel;

  always_comb begin
    // Slots 0,1 belong to the tilemap, 2,3 to the object fetcher.
    tm_own  = ~slot_q[1];
    // The owner always wins; the other side only borrows an idle owner's slot when sharing is on.
    tm_gnt  = bus.tm_req  & (tm_own  | (SHARE_EN & ~bus.obj_req));
    obj_gnt = bus.obj_req & (~tm_own | (SHARE_EN & ~bus.tm_req));

    vaddr_sel = '0;
    laddr_sel = '0;
    if (tm_gnt) begin
      vaddr_sel = bus.tm_vaddr;
      laddr_sel = bus.tm_laddr;
    end else if (obj_gnt) begin
      vaddr_sel = bus.obj_vaddr;
      laddr_sel = bus.obj_laddr;
    end

    slot_d     = sync ? 2'd0 : slot_q + 2'd1;
    slot_cen_d = (slot_d == 2'd0);

    // The oldest stage lines up with the RAM output of the matching grant.
    pv_d = (pv_q << 1) | pipe_t'(tm_gnt | obj_gnt);
    pt_d = (pt_q << 1) | pipe_t'(obj_gnt);

    ret_vld = pv_q[MEM_LAT-1];
    ret_obj = pt_q[MEM_LAT-1];

    tm_dvalid_d  = ret_vld & ~ret_obj;
    obj_dvalid_d = ret_vld & ret_obj;

    tm_vdata_d  = tm_dvalid_d  ? bus.vram_q : tm_vdata_q;
    tm_ldata_d  = tm_dvalid_d  ? bus.lut_q  : tm_ldata_q;
    obj_vdata_d = obj_dvalid_d ? bus.vram_q : obj_vdata_q;
    obj_ldata_d = obj_dvalid_d ? bus.lut_q  : obj_ldata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      slot_cen_q   <= 1'b0;
      pv_q         <= '0;
      pt_q         <= '0;
      tm_dvalid_q  <= 1'b0;
      obj_dvalid_q <= 1'b0;
      tm_vdata_q   <= '0;
      tm_ldata_q   <= '0;
      obj_vdata_q  <= '0;
      obj_ldata_q  <= '0;
    end else begin
      slot_q       <= slot_d;
      slot_cen_q   <= slot_cen_d;
      pv_q         <= pv_d;
      pt_q         <= pt_d;
      tm_dvalid_q  <= tm_dvalid_d;
      obj_dvalid_q <= obj_dvalid_d;
      tm_vdata_q   <= tm_vdata_d;
      tm_ldata_q   <= tm_ldata_d;
      obj_vdata_q  <= obj_vdata_d;
      obj_ldata_q  <= obj_ldata_d;
    end
  end

  assign bus.tm_ack     = tm_gnt;
  assign bus.obj_ack    = obj_gnt;
  assign bus.vram_addr  = vaddr_sel;
  assign bus.lut_addr   = laddr_sel;
  assign bus.tm_dvalid  = tm_dvalid_q;
  assign bus.tm_vdata   = tm_vdata_q;
  assign bus.tm_ldata   = tm_ldata_q;
  assign bus.obj_dvalid = obj_dvalid_q;
  assign bus.obj_vdata  = obj_vdata_q;
  assign bus.obj_ldata  = obj_ldata_q;
  assign bus.slot       = slot_q;
  assign bus.slot_cen   = slot_cen_q;

endmodule

// File: tb/tb_jtkiwi_gfx_arb.sv
// Bench for jtkiwi_gfx_arb: instance A (MEM_LAT=1, SHARE=1) and instance B (MEM_LAT=3, SHARE=0).
// Stimulus pushes expected returns into a scoreboard; a negedge monitor pops them when dvalid shows up.
// Streams: 0 = A tilemap, 1 = A object, 2 = B tilemap, 3 = B object.
module tb_jtkiwi_gfx_arb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sync  = 1'b0;
  always #5 clk = ~clk;

  jtkiwi_gfx_arb_if #(.VAW(12), .LAW(10)) ifa ();
  jtkiwi_gfx_arb_if #(.VAW(12), .LAW(10)) ifb ();

  jtkiwi_gfx_arb #(.MEM_LAT(1), .SHARE(1), .VAW(12), .LAW(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .sync(sync), .bus(ifa)
  );
  jtkiwi_gfx_arb #(.MEM_LAT(3), .SHARE(0), .VAW(12), .LAW(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .sync(sync), .bus(ifb)
  );

  // RAM contents: two fixed words, everything else a simple address pattern.
  //   vram 12'h123 -> 16'hA55A, 12'h3C0 -> 16'hF3C0, 12'h456 -> 16'h9456
  //   lut  10'h2F0 -> 8'h7E,    10'h045 -> 8'h79,    10'h011 -> 8'h2D
  function automatic logic [15:0] vfun(logic [11:0] a);
    return (a == 12'h123) ? 16'hA55A : {~a[3:0], a};
  endfunction
  function automatic logic [7:0] lfun(logic [9:0] a);
    return (a == 10'h2F0) ? 8'h7E : (a[7:0] ^ 8'h3C);
  endfunction

  logic [15:0] av_q = '0;
  logic [7:0]  al_q = '0;
  logic [15:0] bv_q [3];
  logic [7:0]  bl_q [3];
  always @(posedge clk) begin
    av_q    <= vfun(ifa.vram_addr);
    al_q    <= lfun(ifa.lut_addr);
    bv_q[0] <= vfun(ifb.vram_addr);
    bl_q[0] <= lfun(ifb.lut_addr);
    bv_q[1] <= bv_q[0];
    bl_q[1] <= bl_q[0];
    bv_q[2] <= bv_q[1];
    bl_q[2] <= bl_q[1];
  end
  assign ifa.vram_q = av_q;
  assign ifa.lut_q  = al_q;
  assign ifb.vram_q = bv_q[2];
  assign ifb.lut_q  = bl_q[2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int es     = 0;   // expected slot number
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          s;
    int          due;
    logic [15:0] v;
    logic [7:0]  l;
  } exp_t;
  exp_t sb[$];

  task automatic push(int s, int lat, logic [15:0] v, logic [7:0] l);
    exp_t e;
    e.s = s; e.due = cyc + lat + 1; e.v = v; e.l = l;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    logic        dv [4];
    logic [15:0] vd [4];
    logic [7:0]  ld [4];
    int          idx;
    dv[0] = ifa.tm_dvalid;  vd[0] = ifa.tm_vdata;  ld[0] = ifa.tm_ldata;
    dv[1] = ifa.obj_dvalid; vd[1] = ifa.obj_vdata; ld[1] = ifa.obj_ldata;
    dv[2] = ifb.tm_dvalid;  vd[2] = ifb.tm_vdata;  ld[2] = ifb.tm_ldata;
    dv[3] = ifb.obj_dvalid; vd[3] = ifb.obj_vdata; ld[3] = ifb.obj_ldata;
    for (int s = 0; s < 4; s++) begin
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].s == s && sb[i].due == cyc) idx = i;
      if (dv[s]) begin
        if (idx < 0) chk($sformatf("s%0d dvalid_unexpected", s), dv[s], 1'b0);
        else begin
          chk($sformatf("s%0d vdata", s), vd[s], sb[idx].v);
          chk($sformatf("s%0d ldata", s), ld[s], sb[idx].l);
          sb.delete(idx);
        end
      end else if (idx >= 0) begin
        chk($sformatf("s%0d dvalid_missing", s), dv[s], 1'b1);
        sb.delete(idx);
      end
    end
  end

  // Sample point of the current cycle; slot of both instances is checked every cycle.
  task automatic mid();
    @(negedge clk);
    chk("slot_a", ifa.slot, es);
    chk("slot_b", ifb.slot, es);
  endtask

  // Advance to just after the next rising edge, tracking the expected slot.
  task automatic nxt();
    @(posedge clk);
    if (!rst_n) es = 0;
    else        es = sync ? 0 : (es + 1) % 4;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifa.tm_req = 0; ifa.tm_vaddr = '0; ifa.tm_laddr = '0;
    ifa.obj_req = 0; ifa.obj_vaddr = '0; ifa.obj_laddr = '0;
    ifb.tm_req = 0; ifb.tm_vaddr = '0; ifb.tm_laddr = '0;
    ifb.obj_req = 0; ifb.obj_vaddr = '0; ifb.obj_laddr = '0;

    // Reset held 5 cycles.
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("rst_cen_a", ifa.slot_cen, 1'b0);
      chk("rst_cen_b", ifb.slot_cen, 1'b0);
      chk("rst_dv_a", {ifa.tm_dvalid, ifa.obj_dvalid}, 2'b00);
      chk("rst_dv_b", {ifb.tm_dvalid, ifb.obj_dvalid}, 2'b00);
      chk("rst_data_a", {ifa.tm_vdata, ifa.obj_ldata}, 24'h0);
      chk("rst_vaddr_a", ifa.vram_addr, 12'h000);
      nxt();
    end
    rst_n = 1'b1;

    // Free-running rotation after release.
    for (int k = 0; k < 9; k++) begin
      mid();
      chk("cen_a", ifa.slot_cen, (k % 4 == 0) && (k > 0));
      chk("cen_b", ifb.slot_cen, (k % 4 == 0) && (k > 0));
      chk("idle_dv_a", ifa.tm_dvalid | ifa.obj_dvalid, 1'b0);
      nxt();
    end

    // Tilemap only on A: owns every slot through sharing.
    ifa.tm_req = 1; ifa.tm_vaddr = 12'h123; ifa.tm_laddr = 10'h045;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk("tmonly_ack", ifa.tm_ack, 1'b1);
      chk("tmonly_oack", ifa.obj_ack, 1'b0);
      chk("tmonly_vaddr", ifa.vram_addr, 12'h123);
      chk("tmonly_laddr", ifa.lut_addr, 10'h045);
      push(0, 1, 16'hA55A, 8'h79);
      nxt();
    end
    ifa.tm_req = 0;
    repeat (3) begin mid(); chk("tmoff_ack", ifa.tm_ack, 1'b0); nxt(); end
    chk("tm_vdata_hold", ifa.tm_vdata, 16'hA55A);

    // Contention on A: owner wins every slot.
    ifa.tm_req = 1; ifa.obj_req = 1; ifa.obj_vaddr = 12'h3C0; ifa.obj_laddr = 10'h2F0;
    for (int k = 0; k < 8; k++) begin
      logic t;
      mid();
      t = (es < 2);
      chk("cont_tack", ifa.tm_ack, t);
      chk("cont_oack", ifa.obj_ack, !t);
      chk("cont_vaddr", ifa.vram_addr, t ? 12'h123 : 12'h3C0);
      if (t) push(0, 1, 16'hA55A, 8'h79);
      else   push(1, 1, 16'hF3C0, 8'h7E);
      nxt();
    end
    ifa.tm_req = 0; ifa.obj_req = 0;
    repeat (3) begin mid(); nxt(); end

    // Strict slots on B: object waits for slots 2,3 although tilemap is idle.
    ifb.obj_req = 1; ifb.obj_vaddr = 12'h456; ifb.obj_laddr = 10'h011;
    for (int k = 0; k < 8; k++) begin
      logic o;
      mid();
      o = (es >= 2);
      chk("strict_oack", ifb.obj_ack, o);
      chk("strict_tack", ifb.tm_ack, 1'b0);
      chk("strict_vaddr", ifb.vram_addr, o ? 12'h456 : 12'h000);
      chk("strict_laddr", ifb.lut_addr, o ? 10'h011 : 10'h000);
      if (o) push(3, 3, 16'h9456, 8'h2D);
      nxt();
    end
    ifb.obj_req = 0;
    repeat (5) begin mid(); nxt(); end

    // Single object grant on B at slot 2, MEM_LAT=3 -> dvalid 4 cycles later.
    while (es != 2) begin mid(); nxt(); end
    ifb.obj_req = 1; ifb.obj_vaddr = 12'h3C0; ifb.obj_laddr = 10'h2F0;
    mid();
    chk("lat_ack", ifb.obj_ack, 1'b1);
    push(3, 3, 16'hF3C0, 8'h7E);
    nxt();
    ifb.obj_req = 0;
    for (int k = 1; k <= 8; k++) begin
      mid();
      chk("lat_dvalid", ifb.obj_dvalid, k == 4);
      chk("lat_ldata", ifb.obj_ldata, (k < 4) ? 8'h2D : 8'h7E);
      nxt();
    end
    chk("lat_vdata_hold", ifb.obj_vdata, 16'hF3C0);

    // Grant at slot 1 on A, reset the following cycle: the return is dropped.
    while (es != 1) begin mid(); nxt(); end
    ifa.tm_req = 1; ifa.tm_vaddr = 12'h123; ifa.tm_laddr = 10'h045;
    mid();
    chk("rstmid_ack", ifa.tm_ack, 1'b1);
    nxt();
    ifa.tm_req = 0;
    rst_n = 1'b0; es = 0;
    mid();
    chk("rstmid_vdata", ifa.tm_vdata, 16'h0000);
    chk("rstmid_ldata_b", ifb.obj_ldata, 8'h00);
    nxt();
    mid();
    nxt();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("rstmid_nodv", ifa.tm_dvalid, 1'b0);
      nxt();
    end

    // Grant at slot 1, then sync pulsed at slot 2 together with an object grant.
    while (es != 1) begin mid(); nxt(); end
    ifa.tm_req = 1;
    mid();
    chk("sync_tack", ifa.tm_ack, 1'b1);
    push(0, 1, 16'hA55A, 8'h79);
    nxt();
    ifa.tm_req = 0; ifa.obj_req = 1; ifa.obj_vaddr = 12'h3C0; ifa.obj_laddr = 10'h2F0;
    sync = 1'b1;
    mid();
    chk("sync_slot2", ifa.slot, 2'd2);
    chk("sync_oack", ifa.obj_ack, 1'b1);
    push(1, 1, 16'hF3C0, 8'h7E);
    nxt();
    sync = 1'b0; ifa.obj_req = 0;
    mid();
    chk("sync_slot0", ifa.slot, 2'd0);
    nxt();
    sync = 1'b1;
    repeat (3) begin nxt(); mid(); chk("sync_hold", ifa.slot, 2'd0); end
    nxt();
    sync = 1'b0;

    repeat (6) begin mid(); nxt(); end
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
